// File: rtl/stack_arbiter.sv
// Round-robin sequencer sharing one LIFO stack between requesters A and B.
// Tracks occupancy locally so overflow/underflow are rejected without touching the stack.
//
// state   | meaning
// INIT    | stack held in reset; two clocks after release
// IDLE    | sample requests, arbitrate, accept or reject
// ISSUE   | drive push/pop strobe and data to the stack
// WAIT    | stack applies the operation at the end of this cycle
// CAPTURE | stack data_out valid; popped data loaded into rdata
// RESP    | one-cycle ack to the winner, err per accept result
module stack_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  op_a,
  input  logic                  op_b,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stk_reset,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  output logic [3:0]            depth,
  output logic                  full,
  output logic                  empty,
  output logic                  busy
);

  localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            init_cnt;
  logic                  win_q, op_q, err_q, last_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [3:0]            depth_q;

  logic                  any_req, win_sel, sel_op, reject;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // On a tie the requester not granted last wins; otherwise the lone requester.
  always_comb begin
    any_req   = req_a | req_b;
    win_sel   = (req_a & req_b) ? ~last_q : req_b;
    sel_op    = win_sel ? op_b : op_a;
    sel_wdata = win_sel ? wdata_b : wdata_a;
    reject    = sel_op ? (depth_q == DEPTH_MAX) : (depth_q == 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:    if (init_cnt == 2'd0) state_nxt = S_IDLE;
      S_IDLE:    if (any_req) state_nxt = reject ? S_RESP : S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT:    state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    stk_reset = (state == S_INIT);
    stk_push  = (state == S_ISSUE) &  op_q;
    stk_pop   = (state == S_ISSUE) & ~op_q;
    ack_a     = (state == S_RESP) & ~win_q;
    ack_b     = (state == S_RESP) &  win_q;
    err       = (state == S_RESP) &  err_q;
    busy      = (state != S_IDLE);
  end

  // last_q resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_cnt <= 2'd1;
      win_q    <= 1'b0;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b1;
      wdata_q  <= '0;
      rdata_q  <= '0;
      depth_q  <= 4'd0;
    end else begin
      if (state == S_INIT && init_cnt != 2'd0)
        init_cnt <= init_cnt - 2'd1;
      if (state == S_IDLE && any_req) begin
        win_q   <= win_sel;
        last_q  <= win_sel;
        op_q    <= sel_op;
        wdata_q <= sel_wdata;
        err_q   <= reject;
        if (!reject)
          depth_q <= sel_op ? depth_q + 4'd1 : depth_q - 4'd1;
      end
      if (state == S_CAPTURE && !op_q)
        rdata_q <= stk_data_out;
    end
  end

  assign stk_data_in = wdata_q;
  assign rdata       = rdata_q;
  assign depth       = depth_q;
  assign full        = (depth_q == DEPTH_MAX);
  assign empty       = (depth_q == 4'd0);

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural LIFO standing in for the stack.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, op_a = 1'b0, op_b = 1'b0;
  logic [7:0] wdata_a = '0, wdata_b = '0;
  logic       ack_a, ack_b, err, stk_reset, stk_push, stk_pop, full, empty, busy;
  logic [7:0] rdata, stk_data_in, stk_data_out;
  logic [3:0] depth;

  int checks = 0;
  int failures = 0;

  stack_arbiter #(.DATA_WIDTH(8), .DEPTH(15)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .err(err), .rdata(rdata),
    .stk_reset(stk_reset), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .depth(depth), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stack model: strobes registered at end of ISSUE, applied at end of WAIT.
  logic [7:0] mem [16];
  logic [4:0] sp;
  logic       p_push, p_pop;
  logic [7:0] p_data;
  always @(posedge clk) begin
    if (stk_reset) begin
      sp <= '0; p_push <= 1'b0; p_pop <= 1'b0; p_data <= '0; stk_data_out <= '0;
    end else begin
      if (p_push && sp < 5'd16) begin
        mem[sp[3:0]] <= p_data;
        sp <= sp + 5'd1;
      end else if (p_pop && sp != 5'd0) begin
        stk_data_out <= mem[sp[3:0] - 4'd1];
        sp <= sp - 5'd1;
      end
      p_push <= stk_push;
      p_pop  <= stk_pop;
      p_data <= stk_data_in;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Release reset, then expect two INIT cycles before IDLE.
  task automatic init_seq(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_init1_stk_reset"}, stk_reset, 1);
    chk({tag, "_init1_busy"}, busy, 1);
    chk({tag, "_init1_ack_a"}, ack_a, 0);
    @(posedge clk); #1;
    chk({tag, "_idle_stk_reset"}, stk_reset, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_empty"}, empty, 1);
    chk({tag, "_idle_depth"}, depth, 0);
    chk({tag, "_idle_ack_a"}, ack_a, 0);
  endtask

  task automatic do_op(input string nm, input logic sel, input logic op, input logic [7:0] wd,
                       input logic exp_err, input logic [7:0] exp_rd, input logic [3:0] exp_dep);
    int   cnt;
    logic got, saw_strobe, bad_strobe, bad_ack;
    cnt = 0; got = 0; saw_strobe = 0; bad_strobe = 0; bad_ack = 0;
    if (!sel) begin req_a = 1'b1; op_a = op; wdata_a = wd; end
    else      begin req_b = 1'b1; op_b = op; wdata_b = wd; end
    while (!got && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) chk({nm, "_depth_at_accept"}, depth, exp_dep);
      if (stk_push || stk_pop) saw_strobe = 1;
      if ((stk_push && !op) || (stk_pop && op) || (stk_push && stk_data_in !== wd)) bad_strobe = 1;
      if (sel ? ack_a : ack_b) bad_ack = 1;
      if (sel ? ack_b : ack_a) got = 1;
    end
    chk({nm, "_acked"}, got, 1);
    chk({nm, "_latency"}, cnt, exp_err ? 1 : 4);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_rdata"}, rdata, exp_rd);
    chk({nm, "_depth"}, depth, exp_dep);
    chk({nm, "_full"}, full, exp_dep == 4'd15);
    chk({nm, "_empty"}, empty, exp_dep == 4'd0);
    chk({nm, "_strobe_seen"}, saw_strobe, !exp_err);
    chk({nm, "_strobe_ok"}, bad_strobe, 0);
    chk({nm, "_other_ack"}, bad_ack, 0);
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_err_after"}, err, 0);
  endtask

  typedef struct {
    logic       sel;
    logic       op;
    logic [7:0] wdata;
    logic       exp_err;
    logic [7:0] exp_rd;
    logic [3:0] exp_dep;
  } vec_t;

  vec_t vecs [5];
  logic order [4];

  initial begin
    vecs[0] = '{sel: 1'b0, op: 1'b1, wdata: 8'h11, exp_err: 1'b0, exp_rd: 8'h00, exp_dep: 4'd1};
    vecs[1] = '{sel: 1'b0, op: 1'b1, wdata: 8'h22, exp_err: 1'b0, exp_rd: 8'h00, exp_dep: 4'd2};
    vecs[2] = '{sel: 1'b1, op: 1'b0, wdata: 8'h00, exp_err: 1'b0, exp_rd: 8'h22, exp_dep: 4'd1};
    vecs[3] = '{sel: 1'b1, op: 1'b0, wdata: 8'h00, exp_err: 1'b0, exp_rd: 8'h11, exp_dep: 4'd0};
    vecs[4] = '{sel: 1'b0, op: 1'b0, wdata: 8'h00, exp_err: 1'b1, exp_rd: 8'h11, exp_dep: 4'd0};

    // Reset with a pop request from A held throughout.
    req_a = 1'b1; op_a = 1'b0;
    @(posedge clk); #1;
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strobes", {stk_push, stk_pop}, 0);
    chk("rst_data_in", stk_data_in, 0);
    chk("rst_stk_reset", stk_reset, 1);
    chk("rst_flags", {depth, empty, full, busy}, {4'd0, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    init_seq("rel");
    @(posedge clk); #1;
    chk("held_req_ack_a", ack_a, 1);
    chk("held_req_err", err, 1);
    chk("held_req_rdata", rdata, 0);
    req_a = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].op, vecs[i].wdata,
            vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_dep);

    for (int i = 0; i < 15; i++)
      do_op($sformatf("fill%0d", i), 1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 8'h11, 4'(i + 1));
    do_op("overflow", 1'b0, 1'b1, 8'hEE, 1'b1, 8'h11, 4'd15);
    do_op("pop_top", 1'b1, 1'b0, 8'h00, 1'b0, 8'h3E, 4'd14);

    // Reset asserted during WAIT of a push.
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h77;
    @(posedge clk); #1;
    chk("mid_issue_push", stk_push, 1);
    chk("mid_issue_data", stk_data_in, 8'h77);
    chk("mid_issue_depth", depth, 15);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_strobes", {stk_push, stk_pop}, 0);
    chk("mid_rst_acks", {ack_a, ack_b, err}, 0);
    chk("mid_rst_depth", depth, 0);
    chk("mid_rst_stk_reset", stk_reset, 1);
    chk("mid_rst_busy", busy, 1);
    req_a = 1'b0;
    @(posedge clk); #1;
    init_seq("mid");
    do_op("post_rst_underflow", 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 4'd0);

    // Both requesters held with pushes: expect A, B, A, B.
    begin
      int   n, cyc;
      logic both;
      n = 0; cyc = 0; both = 0;
      req_a = 1'b1; op_a = 1'b1; wdata_a = 8'hA0;
      req_b = 1'b1; op_b = 1'b1; wdata_b = 8'hB0;
      while (n < 4 && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (ack_a && ack_b) both = 1;
        if (ack_a || ack_b) begin
          order[n] = ack_b;
          n++;
        end
      end
      req_a = 1'b0; req_b = 1'b0;
      chk("tie_count", n, 4);
      chk("tie_cycles", cyc, 19);
      chk("tie_both", both, 0);
      chk("tie_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
      @(posedge clk); #1;
      chk("tie_depth", depth, 4);
    end
    do_op("tie_pop", 1'b0, 1'b0, 8'h00, 1'b0, 8'hB0, 4'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Sequencer that shares one 16-location LIFO `stack` instance between two requesters (A, B). It grants one request at a time using round-robin order, drives the stack's `push`/`pop`/`data_in`/`reset` pins, and tracks stack occupancy so it can reject overflow and underflow without relying on the stack's `error` output. Popped data returns to the winning requester with a one-cycle acknowledge. It sits between client logic and the `stack` datapath; the stack is instantiated beside it, not inside it.

## Interface
Parameters
- `DATA_WIDTH`, 8: data width; must match the stack.
- `DEPTH`, 15: usable stack entries. The stack faults on a push at pointer 0, so 15 of its 16 locations are usable.

Ports
- `clk`  in  1  single clock for this block and the stack.
- `reset`  in  1  asynchronous, active-low reset; asserted 0.
- `req_a`, `req_b`  in  1  request; held until the matching ack.
- `op_a`, `op_b`  in  1  1 = push, 0 = pop; held with req.
- `wdata_a`, `wdata_b`  in  DATA_WIDTH  push data; held with req.
- `ack_a`, `ack_b`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with ack; 1 = rejected (overflow or underflow).
- `rdata`  out  DATA_WIDTH  popped data; valid with ack of a successful pop.
- `stk_reset`  out  1  to stack `reset` (active-high, synchronous at the stack).
- `stk_push`, `stk_pop`  out  1  to stack `push`/`pop`.
- `stk_data_in`  out  DATA_WIDTH  to stack `data_in`.
- `stk_data_out`  in  DATA_WIDTH  from stack `data_out`.
- `depth`  out  4  current occupancy, 0..DEPTH.
- `full`, `empty`, `busy`  out  1  depth==DEPTH, depth==0, state≠IDLE.

## Operation
- FSM states: INIT, IDLE, ISSUE, WAIT, CAPTURE, RESP.
- INIT
  - Entered asynchronously on reset.
  - `stk_reset`=1 while `reset`=0 and for 2 clocks after release.
  - Then moves to IDLE. Requests are ignored in INIT.
- IDLE: samples `req_a`/`req_b`. Requests are sampled only in this state.
- Arbitration
  - A lone requester wins.
  - If both request, the winner is the one not granted last.
  - After reset the last grant is B, so A wins the first tie.
- Accept (edge leaving IDLE)
  - Latch winner id, op and wdata.
  - If push with depth==DEPTH, or pop with depth==0: reject. Go straight to RESP with `err`=1; depth unchanged; no stack strobe.
  - Otherwise: depth ±1 at this edge, go to ISSUE.
- ISSUE (1 cycle): `stk_push` or `stk_pop`=1, `stk_data_in`=latched wdata. Next state WAIT.
- WAIT (1 cycle): stack applies the operation at the end of this cycle. Next state CAPTURE.
- CAPTURE (1 cycle): `stk_data_out` is valid. On a pop, `rdata` loads it at the end of the cycle. Next state RESP.
- RESP (1 cycle): the winner's ack=1, `err` per accept result. Next state IDLE.
- `rdata` changes only on a successful pop and holds otherwise. `err`=0 outside RESP.
- A requester must drop or change req in the cycle after its ack. If req stays high it is re-sampled as a new request.
- The non-winning request stays pending and is evaluated in the next IDLE.

## Timing
- Reset values: `ack_a`=`ack_b`=`err`=0, `rdata`=0, `stk_push`=`stk_pop`=0, `stk_data_in`=0, `stk_reset`=1, `depth`=0, `empty`=1, `full`=0, `busy`=1 (INIT).
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Accepted operation: accept edge E0, ISSUE after E0, ack high in the cycle after E3 (4 cycles).
- Rejected operation: ack and `err` high in the cycle after E0 (1 cycle).
- Throughput: one accepted op per 5 cycles; one reject per 2 cycles.
- `depth`/`full`/`empty` update at the accept edge, before the stack completes.
- Simultaneous `req_a` and `req_b`: exactly one ack, never both, in any cycle.
- Reset mid-operation
  - Aborts immediately and clears all state.
  - Any strobe in flight drops asynchronously.
  - `stk_reset` re-initialises the stack; previously stored data is lost.

## Test plan
- Reset release: `stk_reset` stays high for 2 clocks after release and `busy`=1, then IDLE with `empty`=1 and `depth`=0. A `req_a` held through INIT is not acked until after INIT.
- A pushes 0x11, 0x22; B pops twice: rdata 0x22 then 0x11, `err`=0, each ack 4 cycles after its accept edge, final `depth`=0.
- Underflow: pop on empty: ack with `err`=1 one cycle after accept, `stk_pop` never asserted, `rdata` unchanged.
- Fill: 15 pushes, then a 16th push gives `err`=1 with `full`=1 and `depth`=15. The next pop returns the 15th value.
- A and B both held high with pushes 0xA0 and 0xB0 after reset: grant order A, B, A, B. A pop then returns the last pushed value.
- Assert `reset` during WAIT of a push: all strobes and acks drop at once, `depth`=0, and the INIT sequence repeats.
